// File: rtl/clkdiv_clock_source.sv
// Programmable divided-clock source; o is a registered clock output that always parks low.
// Optional `ifdef CLKDIV_PERIOD_COUNT_EN adds a 16-bit count of completed periods.
//   state  | meaning
//   S_IDLE | output parked low, counter idle
//   S_RUN  | counting and toggling o at each terminal count
//   S_STOP | en dropped while high; finish the high phase, then park
module clkdiv_clock_source #(
  parameter int                   DIV_WIDTH = 8,
  parameter logic [DIV_WIDTH-1:0] DIV_INIT  = '0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 div_load,
  input  logic [DIV_WIDTH-1:0] div_value,
  (* CLOCK *)
  output logic                 o,
  output logic                 active,
  output logic                 rise
`ifdef CLKDIV_PERIOD_COUNT_EN
  ,
  output logic [15:0]          periods
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_STOP} state_t;

  state_t               state;
  logic [DIV_WIDTH-1:0] cnt;
  logic [DIV_WIDTH-1:0] div_reg;
  logic [DIV_WIDTH-1:0] pend;
  logic                 pend_valid;
  logic                 tc;
  logic [DIV_WIDTH-1:0] div_next;

  assign tc = (cnt == '0);
  // A same-cycle load beats the pending value; either one commits at TC or on parking.
  assign div_next = div_load ? div_value : (pend_valid ? pend : div_reg);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      o          <= 1'b0;
      active     <= 1'b0;
      rise       <= 1'b0;
      cnt        <= '0;
      div_reg    <= DIV_INIT;
      pend       <= '0;
      pend_valid <= 1'b0;
    end else begin
      rise <= 1'b0;
      case (state)
        S_IDLE: begin
          if (div_load) div_reg <= div_value;
          if (en) begin
            state  <= S_RUN;
            active <= 1'b1;
            cnt    <= div_load ? div_value : div_reg;
          end
        end
        default: begin
          if (!en && !o) begin
            state      <= S_IDLE;
            active     <= 1'b0;
            cnt        <= '0;
            div_reg    <= div_next;
            pend_valid <= 1'b0;
          end else if (tc) begin
            div_reg    <= div_next;
            pend_valid <= 1'b0;
            if (!en) begin
              o      <= 1'b0;
              state  <= S_IDLE;
              active <= 1'b0;
              cnt    <= '0;
            end else begin
              o     <= ~o;
              rise  <= ~o;
              cnt   <= div_next;
              state <= S_RUN;
            end
          end else begin
            cnt   <= cnt - 1'b1;
            state <= en ? S_RUN : S_STOP;
            if (div_load) begin
              pend       <= div_value;
              pend_valid <= 1'b1;
            end
          end
        end
      endcase
    end
  end

`ifdef CLKDIV_PERIOD_COUNT_EN
  logic o_fall;
  assign o_fall = (state != S_IDLE) && tc && o;

  always_ff @(posedge clk) begin
    if (rst)         periods <= '0;
    else if (o_fall) periods <= periods + 16'd1;
  end
`endif

endmodule

// File: doc/clkdiv_clock_source.md
Name: clkdiv_clock_source

Overview:
- Whitebox clock-generating block: the output-side counterpart of a block whose input carries a clock attribute.
- Derives a divided clock from `clk` and drives it on output `o`, which carries the `(* CLOCK *)` attribute so V2X classifies it as a clock output.
- Divide ratio is programmable at run time.
- Start and stop are glitch-free, and the output always parks low.

Parameters:
- DIV_WIDTH, 8, width of the half-period divide value.
- DIV_INIT, 0, divide value loaded at reset (half-period = DIV_INIT+1 clk cycles).

Ports:
- clk  input  1  block clock; the only clock input.
- rst  input  1  synchronous, active-high reset.
- en  input  1  level; request the output clock to run.
- div_load  input  1  one-cycle strobe; capture div_value.
- div_value  input  DIV_WIDTH  new half-period count minus 1.
- o  output  1  divided clock, `(* CLOCK *)` attribute on the port, registered.
- active  output  1  high while state is RUN or STOP.
- rise  output  1  one-cycle strobe, high in the same cycle o goes 0->1.

Behaviour:
- Reset (sync, active-high; overrides everything):
  - state=IDLE; o=0; active=0; rise=0; cnt=0.
  - div_reg=DIV_INIT; pend_valid=0.
- Half-period:
  - Counter cnt (DIV_WIDTH bits) counts down from div_reg.
  - Terminal count (TC) is cnt==0 in RUN/STOP.
  - At TC: o toggles and cnt reloads with div_reg; the reload uses the new value if a pending load is applied at that TC.
  - Period = 2*(div_reg+1) clk cycles; div_reg=0 gives clk/2. Duty is exactly 50%.
- States:
  - IDLE:
    - o=0, active=0.
    - en=1 -> RUN, cnt<=div_reg.
    - First o rise occurs div_reg+1 cycles after the cycle RUN is entered.
  - RUN:
    - Counts and toggles at each TC.
    - en=0 and o=0 -> IDLE next cycle; o stays 0 and cnt is cleared.
    - en=0 and o=1 -> STOP.
  - STOP:
    - Keeps counting. At TC, o falls to 0 and state -> IDLE, so the high phase completes its full length.
    - en=1 during STOP -> back to RUN without disturbing cnt or o.
- Divide load:
  - div_load in IDLE: div_reg<=div_value next cycle.
  - div_load in RUN/STOP: the value is captured into pend and pend_valid is set. At the next TC, div_reg<=pend, pend_valid is cleared, and cnt reloads with pend.
  - div_load in the same cycle as TC: the new value is applied at that TC directly, bypassing pend.
  - A second div_load before the TC overwrites pend (last write wins).
- rise:
  - Asserted combinationally-registered with o, i.e. in the first cycle o==1 of each high phase.
  - Never asserted in IDLE.
- Mid-operation reset: o forced to 0 next cycle regardless of phase. This glitch is accepted because reset is system-level.
- No combinational path from any input to o; o comes directly from a flop.

Optional Feature:
- CLKDIV_PERIOD_COUNT_EN, when defined:
  - Adds output `periods` [15:0], reset 0.
  - Increments on every 1->0 transition of o, including the final fall in STOP.
  - Wraps 16'hFFFF -> 0; holds in IDLE.
- When undefined: port absent, no counter logic; all other behaviour identical.

Test Plan:
- Reset, en=0 for 10 cycles -> o=0, active=0, rise=0 throughout; div_reg=DIV_INIT(0).
- div_load with div_value=2 in IDLE, then en=1 -> RUN; first o rise 3 cycles after RUN entry; period 6 cycles, 3 high/3 low for 4 periods; rise pulses once per period.
- Running at div 2, div_load div_value=0 mid-high-phase -> current half completes at 3 cycles, then o toggles every cycle (period 2).
- en=0 one cycle after o rises (div 3) -> state STOP, o stays high the full 4 cycles, falls, then IDLE, active=0; no further toggles.
- en=0 during low phase -> IDLE next cycle, o remains 0, no runt pulse. rst asserted while o=1 -> o=0 and active=0 the next cycle.
- With CLKDIV_PERIOD_COUNT_EN, div 0, run 70000 cycles -> periods = 35000 mod 65536 = 35000. Preload periods to 65535 via 65535 completed periods -> one more fall gives periods=0.
